// File: rtl/ps2_pkg.sv
// Shared constants, state encoding and byte-list helpers for the PS/2 host command path.
package ps2_pkg;

    localparam logic [1:0] OP_LED   = 2'd0;
    localparam logic [1:0] OP_RATE  = 2'd1;
    localparam logic [1:0] OP_RESET = 2'd2;
    localparam logic [1:0] OP_RAW   = 2'd3;

    localparam logic [7:0] B_LED    = 8'hED;
    localparam logic [7:0] B_RATE   = 8'hF3;
    localparam logic [7:0] B_RESET  = 8'hFF;
    localparam logic [7:0] B_ACK    = 8'hFA;
    localparam logic [7:0] B_RESEND = 8'hFE;
    localparam logic [7:0] B_BATERR = 8'hFC;
    localparam logic [7:0] B_BATOK  = 8'hAA;

    typedef enum logic [3:0] {
        S_IDLE,
        S_INHIBIT,
        S_RTS,
        S_TX,
        S_LACK,
        S_WRESP,
        S_WBAT,
        S_RETRY,
        S_DONE,
        S_ERR
    } state_t;

    function automatic logic two_byte(input logic [1:0] op);
        return (op == OP_LED) || (op == OP_RATE);
    endfunction

    // Byte idx of the list {cmd, arg} (LED/RATE), {0xFF} (RESET) or {arg} (RAW).
    function automatic logic [7:0] cmd_byte(input logic [1:0] op, input logic [7:0] arg,
                                            input logic idx);
        logic [7:0] b;
        case (op)
            OP_LED:   b = idx ? arg : B_LED;
            OP_RATE:  b = idx ? arg : B_RATE;
            OP_RESET: b = B_RESET;
            default:  b = arg;
        endcase
        return b;
    endfunction

    function automatic logic odd_par(input logic [7:0] b);
        return ~^b;
    endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Eight-sample glitch filter for one PS/2 line; the level only moves on eight equal samples.
module ps2_line_filter (
    input  logic clk,
    input  logic rst,
    input  logic line_i,
    output logic lvl_o,
    output logic fall_o
);

    logic [7:0] shreg_q;
    logic       lvl_q;
    logic       lvl_d;
    logic       fall_q;

    always_comb begin
        lvl_d = lvl_q;
        if (shreg_q == '1) begin
            lvl_d = 1'b1;
        end else if (shreg_q == '0) begin
            lvl_d = 1'b0;
        end
    end

    // Idle PS/2 lines float high, so the filter wakes up in that state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg_q <= '1;
            lvl_q   <= 1'b1;
            fall_q  <= 1'b0;
        end else begin
            shreg_q <= {shreg_q[6:0], line_i};
            lvl_q   <= lvl_d;
            fall_q  <= lvl_q & ~lvl_d;
        end
    end

    assign lvl_o  = lvl_q;
    assign fall_o = fall_q;

endmodule

// File: rtl/ps2_cmd_ctrl.sv
// Host-to-keyboard command sequencer: inhibit, request-to-send, bit shifting, line ACK,
// reply handling with resend/timeout, and the BAT wait after a reset command.
module ps2_cmd_ctrl
    import ps2_pkg::*;
#(
    parameter int unsigned INHIBIT_CYC = 2500,
    parameter int unsigned TIMEOUT_CYC = 500000,
    parameter int unsigned BAT_CYC     = 12500000,
    parameter int unsigned MAX_RETRY   = 3
) (
    input  logic       clk25,
    input  logic       clr,
    input  logic       cmd_req,
    input  logic [1:0] cmd_op,
    input  logic [7:0] cmd_arg,
    output logic       cmd_busy,
    output logic       cmd_done,
    output logic       cmd_err,
    input  logic       PS2C,
    input  logic       PS2D,
    output logic       ps2c_oe,
    output logic       ps2d_oe,
    input  logic [7:0] rx_code,
    input  logic       rx_valid,
    output logic       rx_mask
);

    localparam int unsigned CMAX = (BAT_CYC > INHIBIT_CYC) ? BAT_CYC : INHIBIT_CYC;
    localparam int CW = $clog2(CMAX + 1);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    logic c_lvl_unused;
    logic c_fall;
    logic d_lvl;
    logic d_fall_unused;

    ps2_line_filter u_clk_filt (
        .clk    (clk25),
        .rst    (clr),
        .line_i (PS2C),
        .lvl_o  (c_lvl_unused),
        .fall_o (c_fall)
    );

    ps2_line_filter u_dat_filt (
        .clk    (clk25),
        .rst    (clr),
        .line_i (PS2D),
        .lvl_o  (d_lvl),
        .fall_o (d_fall_unused)
    );

    state_t          state_q;
    logic [1:0]      op_q;
    logic [7:0]      arg_q;
    logic            idx_q;
    logic [RW-1:0]   retry_q;
    logic [3:0]      bit_q;
    logic [CW-1:0]   cnt_q;
    logic [TW-1:0]   tmo_q;
    logic            busy_q;
    logic            done_q;
    logic            err_q;
    logic            c_oe_q;
    logic            d_oe_q;
    logic            mask_q;

    logic [7:0] cur_byte;
    logic       last_byte;
    logic       tmo_hit;

    assign cur_byte  = cmd_byte(op_q, arg_q, idx_q);
    assign last_byte = !two_byte(op_q) || idx_q;
    assign tmo_hit   = (tmo_q == TW'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk25 or posedge clr) begin
        if (clr) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            arg_q   <= '0;
            idx_q   <= 1'b0;
            retry_q <= '0;
            bit_q   <= '0;
            cnt_q   <= '0;
            tmo_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            c_oe_q  <= 1'b0;
            d_oe_q  <= 1'b0;
            mask_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (cmd_req) begin
                        op_q    <= cmd_op;
                        arg_q   <= cmd_arg;
                        idx_q   <= 1'b0;
                        retry_q <= '0;
                        busy_q  <= 1'b1;
                        c_oe_q  <= 1'b1;
                        mask_q  <= 1'b1;
                        cnt_q   <= '0;
                        state_q <= S_INHIBIT;
                    end
                end
                S_INHIBIT: begin
                    if (cnt_q == CW'(INHIBIT_CYC - 1)) begin
                        c_oe_q  <= 1'b0;
                        d_oe_q  <= 1'b1;
                        tmo_q   <= '0;
                        state_q <= S_RTS;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_RTS, S_TX, S_LACK: begin
                    if (tmo_hit) begin
                        c_oe_q  <= 1'b0;
                        d_oe_q  <= 1'b0;
                        mask_q  <= 1'b0;
                        state_q <= S_RETRY;
                    end else begin
                        tmo_q <= tmo_q + 1'b1;
                        if (state_q == S_RTS) begin
                            bit_q   <= '0;
                            state_q <= S_TX;
                        end else if (state_q == S_TX) begin
                            // Falls 1..8 carry data LSB first, 9 parity, 10 releases for the stop bit.
                            if (c_fall) begin
                                bit_q <= bit_q + 1'b1;
                                if (bit_q < 4'd8) begin
                                    d_oe_q <= ~cur_byte[bit_q[2:0]];
                                end else if (bit_q == 4'd8) begin
                                    d_oe_q <= ~odd_par(cur_byte);
                                end else begin
                                    d_oe_q  <= 1'b0;
                                    state_q <= S_LACK;
                                end
                            end
                        end else if (c_fall) begin
                            mask_q  <= 1'b0;
                            state_q <= d_lvl ? S_RETRY : S_WRESP;
                        end
                    end
                end
                S_WRESP: begin
                    if (rx_valid && (rx_code == B_ACK)) begin
                        idx_q <= idx_q + 1'b1;
                        if (!last_byte) begin
                            retry_q <= '0;
                            c_oe_q  <= 1'b1;
                            mask_q  <= 1'b1;
                            cnt_q   <= '0;
                            state_q <= S_INHIBIT;
                        end else if (op_q == OP_RESET) begin
                            cnt_q   <= '0;
                            state_q <= S_WBAT;
                        end else begin
                            state_q <= S_DONE;
                        end
                    end else if (rx_valid && (rx_code == B_RESEND)) begin
                        state_q <= S_RETRY;
                    end else if (tmo_hit) begin
                        state_q <= S_RETRY;
                    end else begin
                        tmo_q <= tmo_q + 1'b1;
                    end
                end
                S_WBAT: begin
                    if (rx_valid && (rx_code == B_BATOK)) begin
                        state_q <= S_DONE;
                    end else if (rx_valid && (rx_code == B_BATERR)) begin
                        state_q <= S_ERR;
                    end else if (cnt_q == CW'(BAT_CYC - 1)) begin
                        state_q <= S_ERR;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_RETRY: begin
                    if (retry_q == RW'(MAX_RETRY)) begin
                        state_q <= S_ERR;
                    end else begin
                        retry_q <= retry_q + 1'b1;
                        c_oe_q  <= 1'b1;
                        mask_q  <= 1'b1;
                        cnt_q   <= '0;
                        state_q <= S_INHIBIT;
                    end
                end
                S_DONE, S_ERR: begin
                    done_q  <= (state_q == S_DONE);
                    err_q   <= (state_q == S_ERR);
                    busy_q  <= 1'b0;
                    c_oe_q  <= 1'b0;
                    d_oe_q  <= 1'b0;
                    mask_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign cmd_busy = busy_q;
    assign cmd_done = done_q;
    assign cmd_err  = err_q;
    assign ps2c_oe  = c_oe_q;
    assign ps2d_oe  = d_oe_q;
    assign rx_mask  = mask_q;

endmodule
